// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT post-processing blocks.
package fft_pkg;

  localparam int N_LOG2 = 9;
  localparam int WIDTH  = 32;
  localparam int HALF   = WIDTH / 2;

  typedef struct packed {
    logic signed [HALF-1:0] re;
    logic signed [HALF-1:0] im;
  } bin_word_t;

  typedef logic [WIDTH-1:0]  mag_t;
  typedef logic [N_LOG2-1:0] bin_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_REPORT
  } pf_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage magnitude-squared pipeline (re^2 + im^2) with index/window sideband.
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      flush_i,
  input  logic      valid_i,
  input  bin_word_t data_i,
  input  bin_idx_t  idx_i,
  input  logic      win_i,
  output logic      valid_o,
  output mag_t      mag_o,
  output bin_idx_t  idx_o,
  output logic      win_o
);

  logic signed [WIDTH-1:0] re_ext;
  logic signed [WIDTH-1:0] im_ext;

  logic             s1_valid_q;
  logic             s1_win_q;
  bin_idx_t         s1_idx_q;
  logic [WIDTH-2:0] re_sq_q;
  logic [WIDTH-2:0] im_sq_q;

  logic     s2_valid_q;
  logic     s2_win_q;
  bin_idx_t s2_idx_q;
  mag_t     s2_mag_q;

  assign re_ext = WIDTH'(data_i.re);
  assign im_ext = WIDTH'(data_i.im);

  // Each square is at most 2^30, so it fits in WIDTH-1 unsigned bits.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: datapath registers are reset as well so outputs are never X after reset.
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_win_q   <= 1'b0;
      s1_idx_q   <= '0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_win_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_mag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
      s1_valid_q <= valid_i;
      s1_win_q   <= win_i;
      s1_idx_q   <= idx_i;
      re_sq_q    <= (WIDTH-1)'(re_ext * re_ext);
      im_sq_q    <= (WIDTH-1)'(im_ext * im_ext);
      s2_valid_q <= s1_valid_q & ~flush_i;
      s2_win_q   <= s1_win_q;
      s2_idx_q   <= s1_idx_q;
      s2_mag_q   <= {1'b0, re_sq_q} + {1'b0, im_sq_q};
    end
  end

  assign valid_o = s2_valid_q;
  assign mag_o   = s2_mag_q;
  assign idx_o   = s2_idx_q;
  assign win_o   = s2_win_q;

endmodule

// File: rtl/fft_peak_finder.sv
// Per-frame peak search over FFT bins: reports the strongest in-window bin
// and its two neighbour magnitudes for parabolic interpolation.
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int   MIN_BIN = 1,
  parameter int   MAX_BIN = 255,
  parameter mag_t THRESH  = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              bin_valid,
  input  logic [WIDTH-1:0]  bin_data,
  output logic              peak_valid,
  output logic              peak_found,
  output logic [N_LOG2-1:0] peak_bin,
  output logic [WIDTH-1:0]  peak_mag,
  output logic [WIDTH-1:0]  prev_mag,
  output logic [WIDTH-1:0]  next_mag,
  output logic              busy
);

  localparam bin_idx_t MIN_IDX = bin_idx_t'(MIN_BIN);
  localparam bin_idx_t MAX_IDX = bin_idx_t'(MAX_BIN);

  pf_state_t state_q, state_d;
  bin_idx_t  cnt_q, cnt_d;
  logic      drain_q, drain_d;

  mag_t     max_q, max_d;
  bin_idx_t max_bin_q, max_bin_d;
  mag_t     prev_cand_q, prev_cand_d;
  mag_t     next_cand_q, next_cand_d;
  mag_t     last_mag_q, last_mag_d;
  logic     pending_q, pending_d;

  logic     peak_valid_q, peak_valid_d;
  logic     peak_found_q, peak_found_d;
  bin_idx_t peak_bin_q, peak_bin_d;
  mag_t     peak_mag_q, peak_mag_d;
  mag_t     prev_mag_q, prev_mag_d;
  mag_t     next_mag_q, next_mag_d;

  logic     start;
  logic     accept;
  logic     clear;
  bin_idx_t idx;
  logic     in_win;

  logic     s2_valid;
  logic     s2_win;
  bin_idx_t s2_idx;
  mag_t     s2_mag;

  assign start  = frame_start & bin_valid;
  assign in_win = (idx >= MIN_IDX) && (idx <= MAX_IDX);

  // Restart flushes bins of the abandoned frame still inside the pipeline.
  fft_mag_sq u_mag_sq (
    .clk     (clk),
    .reset   (reset),
    .flush_i (clear),
    .valid_i (accept),
    .data_i  (bin_word_t'(bin_data)),
    .idx_i   (idx),
    .win_i   (in_win),
    .valid_o (s2_valid),
    .mag_o   (s2_mag),
    .idx_o   (s2_idx),
    .win_o   (s2_win)
  );

  always_comb begin
    // NOTE: every variable gets its default first, so no path through this block infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    max_d        = max_q;
    max_bin_d    = max_bin_q;
    prev_cand_d  = prev_cand_q;
    next_cand_d  = next_cand_q;
    last_mag_d   = last_mag_q;
    pending_d    = pending_q;
    peak_valid_d = 1'b0;
    peak_found_d = peak_found_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    prev_mag_d   = prev_mag_q;
    next_mag_d   = next_mag_q;
    accept       = 1'b0;
    clear        = 1'b0;
    idx          = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          clear   = 1'b1;
          idx     = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (start) begin
          accept = 1'b1;
          clear  = 1'b1;
          idx    = '0;
        end else if (bin_valid) begin
          accept = 1'b1;
          if (cnt_q == '1) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        peak_valid_d = 1'b1;
        peak_found_d = (max_q >= THRESH);
        peak_bin_d   = max_bin_q;
        peak_mag_d   = max_q;
        prev_mag_d   = prev_cand_q;
        next_mag_d   = next_cand_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) cnt_d = idx + 1'b1;

    // A new maximum leaves next_cand at 0, which is the answer if the window ends first.
    if (clear) begin
      max_d       = '0;
      max_bin_d   = MIN_IDX;
      prev_cand_d = '0;
      next_cand_d = '0;
      last_mag_d  = '0;
      pending_d   = 1'b0;
    end else if (s2_valid && s2_win) begin
      if (s2_mag > max_q) begin
        max_d       = s2_mag;
        max_bin_d   = s2_idx;
        prev_cand_d = (s2_idx == MIN_IDX) ? '0 : last_mag_q;
        next_cand_d = '0;
        pending_d   = 1'b1;
      end else if (pending_q) begin
        next_cand_d = s2_mag;
        pending_d   = 1'b0;
      end
      last_mag_d = s2_mag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      max_q        <= '0;
      max_bin_q    <= '0;
      prev_cand_q  <= '0;
      next_cand_q  <= '0;
      last_mag_q   <= '0;
      pending_q    <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_found_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      prev_mag_q   <= '0;
      next_mag_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      max_q        <= max_d;
      max_bin_q    <= max_bin_d;
      prev_cand_q  <= prev_cand_d;
      next_cand_q  <= next_cand_d;
      last_mag_q   <= last_mag_d;
      pending_q    <= pending_d;
      peak_valid_q <= peak_valid_d;
      peak_found_q <= peak_found_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      prev_mag_q   <= prev_mag_d;
      next_mag_q   <= next_mag_d;
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_found = peak_found_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign prev_mag   = prev_mag_q;
  assign next_mag   = next_mag_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Streaming consumer directly downstream of the fft core; runs in parallel with its serial readout.
- Takes the fft's per-bin output words ({re[31:16], im[15:0]}, signed Q1.15) one bin per valid cycle.
- Computes magnitude-squared per bin and tracks the largest bin inside a configured search window.
- Once per frame, reports peak bin index, peak magnitude and the two neighbour magnitudes for the tuner's parabolic interpolation logic.

Parameters:
- N_LOG2, 9, log2 of FFT length (frame = 512 bins)
- WIDTH, 32, bin word width; re and im are WIDTH/2 each
- MIN_BIN, 1, lowest bin searched; default excludes DC
- MAX_BIN, 255, highest bin searched; default excludes the mirrored half
- THRESH, 32'h0000_1000, minimum magnitude-squared for a valid detection

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  pulse coincident with bin 0 of a frame (qualified by bin_valid)
- bin_valid  in  1  bin_data valid this cycle
- bin_data  in  WIDTH  {re, im}, two's complement
- peak_valid  out  1  one-cycle pulse: result registers updated
- peak_found  out  1  peak_mag >= THRESH
- peak_bin  out  N_LOG2  index of maximum bin
- peak_mag  out  WIDTH  re^2+im^2 at peak_bin
- prev_mag  out  WIDTH  magnitude at peak_bin-1; 0 if peak_bin==MIN_BIN
- next_mag  out  WIDTH  magnitude at peak_bin+1; 0 if peak_bin==MAX_BIN
- busy  out  1  frame in progress or pipeline not yet drained

Behaviour:
Reset (reset low, asynchronous):
- All outputs 0; FSM in IDLE; bin counter 0.

Magnitude pipeline:
- Stage 1 registers re*re and im*im (signed 16x16, 31-bit unsigned results).
- Stage 2 registers the sum as WIDTH bits unsigned. Max value 2^31 (re=im=-32768); no overflow.
- Latency 2 cycles. The bin index and window flag travel with the data.

Bin counting:
- Index increments on each bin_valid.
- frame_start with bin_valid forces index 0.
- Gaps (bin_valid low) are allowed anywhere.

FSM states:
- IDLE: waits for frame_start & bin_valid -> ACCUM. Clears running max, candidate neighbours, pending flag. bin_valid without frame_start is ignored.
- ACCUM: accepts bins. Accepting index 2^N_LOG2-1 -> DRAIN.
- frame_start in ACCUM: discards the partial frame, restarts at index 0, stays in ACCUM; no peak_valid is issued.
- DRAIN: waits 2 cycles for the pipeline to empty -> REPORT.
- REPORT: latches outputs, pulses peak_valid for 1 cycle -> IDLE.
- busy = (state != IDLE).

Peak tracking (stage-2 output, only when MIN_BIN <= idx <= MAX_BIN):
- mag > running_max (strict): update max and bin; prev_cand = last in-window magnitude (0 if idx==MIN_BIN); set pending_next.
- Ties keep the lower bin.
- The next in-window magnitude with pending_next set loads next_cand and clears pending.
- pending still set at the end of the window (peak at MAX_BIN): next_cand = 0.
- All window magnitudes 0: peak_bin = MIN_BIN, all mags 0, peak_found = 0.

Output timing:
- Output registers hold their values until the next REPORT or reset.
- peak_valid asserts exactly 4 cycles after the cycle that accepts bin 511, assuming continuous valid input.
- Reset mid-frame: immediate return to IDLE, outputs 0, no pulse.

Decomposition:
- Package fft_pkg holds: N_LOG2, WIDTH, the bin-word typedef (struct re/im, signed 16-bit) and the magnitude typedef (unsigned WIDTH).
- Sub-module fft_mag_sq: 2-stage magnitude-squared pipeline carrying index and valid sideband.
- FSM and peak tracking stay in the top.

Test Plan:
1. Single tone: bin 40 = {16'h4000, 16'h0000}, all others 0 -> peak_bin=40, peak_mag=32'h1000_0000, prev=next=0, peak_found=1, peak_valid 4 cycles after bin 511.
2. Neighbours: bins 99/100/101 = re 0x1000/0x2000/0x1800, im 0 -> peak_bin=100, prev_mag=32'h0100_0000, peak_mag=32'h0400_0000, next_mag=32'h0240_0000.
3. Window/ties: bin 0 = 0x7FFF, bin 300 = 0x7FFF, bins 50 and 60 = 0x1000 -> peak_bin=50 (DC and mirror ignored, tie keeps lower bin).
4. Threshold and extremes: all bins {0x0010, 0x0000} -> peak_bin=1, peak_mag=0x100, prev_mag=0, peak_found=0. Separate frame with bin 255 = {0x8000, 0x8000} -> peak_mag=32'h8000_0000, next_mag=0.
5. Restart and gaps: frame_start reasserted at index 200, then a clean frame with bin_valid toggling every other cycle -> exactly one peak_valid, reflecting the second frame only.
6. Reset mid-frame: reset low at index 300 -> outputs 0 immediately, busy=0; the following full frame reports correctly.
